// File: rtl/rd_frame_sched_if.sv
// Command and return-beat bus between the frame scheduler and the read channel user port.
interface rd_frame_sched_if #(
  parameter int AXI_ADDR_WIDTH = 32
);
  logic                      user_rd_req;
  logic [AXI_ADDR_WIDTH-1:0] user_rd_addr;
  logic [12:0]               user_rd_length;
  logic                      user_rd_mode;
  logic [AXI_ADDR_WIDTH-1:0] user_base_addr;
  logic [AXI_ADDR_WIDTH-1:0] user_end_addr;
  logic                      user_rd_req_busy;
  logic                      user_rd_valid;
  logic                      user_rd_last;

  modport master (
    output user_rd_req, user_rd_addr, user_rd_length, user_rd_mode,
    output user_base_addr, user_end_addr,
    input  user_rd_req_busy, user_rd_valid, user_rd_last
  );

  modport slave (
    input  user_rd_req, user_rd_addr, user_rd_length, user_rd_mode,
    input  user_base_addr, user_end_addr,
    output user_rd_req_busy, user_rd_valid, user_rd_last
  );
endinterface

// File: rtl/rd_frame_sched.sv
// Frame read scheduler: splits [base, end) into credit-limited bursts, retires them from
// the returned beat stream, checks burst lengths and reports frame completion.
module rd_frame_sched #(
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int USER_DATA_WIDTH = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ddr_init_done,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      cfg_continuous,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] cfg_end_addr,
  input  logic [12:0]               cfg_rd_length,
  rd_frame_sched_if.master          rd_if,
  output logic                      sched_busy,
  output logic                      frame_done,
  output logic [15:0]               frame_cnt,
  output logic                      len_err
);
  localparam int AW         = AXI_ADDR_WIDTH;
  localparam int BEAT_SHIFT = $clog2(USER_DATA_WIDTH / 8);
  localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [2:0]       MAX_OS   = 3'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_HOLD      = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              stop_pend_r, cont_r;
  logic [AW-1:0]     base_r, end_r, addr_r;
  logic [12:0]       len_cfg_r, length_r, beat_cnt_r;
  logic [AW:0]       cur_addr_r;
  logic [2:0]        outstanding_r;
  logic [12:0]       fifo_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic              req_r, sched_busy_r, frame_done_r, len_err_r;
  logic [15:0]       frame_cnt_r;

  logic [AW:0]       remain_s, len_ext_s;
  logic [12:0]       burst_len_s, burst_beats_s;
  logic              start_ok_s, rd_last_s, retire_s, stray_s, len_mismatch_s;
  logic              stop_now_s, drain_empty_s;
  logic              issue_s, accept_s, frame_end_s, restart_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Burst sizing and beat-stream decode shared by the FSM and the retire logic.
  always_comb begin
    remain_s       = {1'b0, end_r} - cur_addr_r;
    len_ext_s      = {{(AW-12){1'b0}}, len_cfg_r};
    burst_len_s    = (remain_s < len_ext_s) ? remain_s[12:0] : len_cfg_r;
    burst_beats_s  = burst_len_s >> BEAT_SHIFT;
    start_ok_s     = start & ~stop & (cfg_base_addr < cfg_end_addr);
    rd_last_s      = rd_if.user_rd_valid & rd_if.user_rd_last;
    retire_s       = rd_last_s & (outstanding_r != 3'd0);
    stray_s        = rd_last_s & (outstanding_r == 3'd0);
    len_mismatch_s = retire_s & ((beat_cnt_r + 13'd1) != fifo_mem_r[rd_ptr_r]);
    stop_now_s     = stop_pend_r | stop;
    drain_empty_s  = (outstanding_r - {2'b00, retire_s}) == 3'd0;
  end

  // Next-state decode; stop is checked before issuing so a pending stop never adds a burst.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    accept_s    = 1'b0;
    frame_end_s = 1'b0;
    restart_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ddr_init_done ? ST_ISSUE : ST_WAIT_INIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_INIT: begin
        if (stop) begin
          state_nxt_s = ST_IDLE;
        end else if (ddr_init_done) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_WAIT_INIT;
        end
      end
      ST_ISSUE: begin
        if (stop_now_s) begin
          state_nxt_s = ST_DRAIN;
        end else if (!rd_if.user_rd_req_busy && (outstanding_r < MAX_OS)) begin
          issue_s     = 1'b1;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (stop_now_s || (cur_addr_r == {1'b0, end_r})) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (!drain_empty_s) begin
          state_nxt_s = ST_DRAIN;
        end else if (stop_now_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          frame_end_s = 1'b1;
          if (cont_r) begin
            restart_s   = 1'b1;
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, latched configuration and window cursor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      stop_pend_r <= 1'b0;
      cont_r      <= 1'b0;
      base_r      <= '0;
      end_r       <= '0;
      len_cfg_r   <= 13'd0;
      cur_addr_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s || (state_nxt_s == ST_IDLE)) begin
        stop_pend_r <= 1'b0;
      end else if (stop && (state_r != ST_IDLE)) begin
        stop_pend_r <= 1'b1;
      end
      if (accept_s) begin
        cont_r     <= cfg_continuous;
        base_r     <= cfg_base_addr;
        end_r      <= cfg_end_addr;
        len_cfg_r  <= cfg_rd_length;
        cur_addr_r <= {1'b0, cfg_base_addr};
      end else if (restart_s) begin
        cur_addr_r <= {1'b0, base_r};
      end else if (issue_s) begin
        cur_addr_r <= cur_addr_r + {{(AW-12){1'b0}}, burst_len_s};
      end
    end
  end

  // Expected-beat FIFO, credit counter and beat counting of the returned stream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_mem_r[i] <= 13'd0;
      end
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      outstanding_r <= 3'd0;
      beat_cnt_r    <= 13'd0;
    end else begin
      if (issue_s) begin
        fifo_mem_r[wr_ptr_r] <= burst_beats_s;
        wr_ptr_r             <= ptr_inc(wr_ptr_r);
      end
      if (retire_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({issue_s, retire_s})
        2'b10:   outstanding_r <= outstanding_r + 3'd1;
        2'b01:   outstanding_r <= outstanding_r - 3'd1;
        default: outstanding_r <= outstanding_r;
      endcase
      if (retire_s) begin
        beat_cnt_r <= 13'd0;
      end else if (rd_if.user_rd_valid && !rd_if.user_rd_last && (outstanding_r != 3'd0)) begin
        beat_cnt_r <= beat_cnt_r + 13'd1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_r        <= 1'b0;
      addr_r       <= '0;
      length_r     <= 13'd0;
      sched_busy_r <= 1'b0;
      frame_done_r <= 1'b0;
      frame_cnt_r  <= 16'd0;
      len_err_r    <= 1'b0;
    end else begin
      req_r        <= issue_s;
      sched_busy_r <= (state_nxt_s != ST_IDLE);
      frame_done_r <= frame_end_s;
      if (issue_s) begin
        addr_r   <= cur_addr_r[AW-1:0];
        length_r <= burst_len_s;
      end
      if (frame_end_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (stray_s || len_mismatch_s) begin
        len_err_r <= 1'b1;
      end else if (accept_s) begin
        len_err_r <= 1'b0;
      end
    end
  end

  assign rd_if.user_rd_req    = req_r;
  assign rd_if.user_rd_addr   = addr_r;
  assign rd_if.user_rd_length = length_r;
  assign rd_if.user_rd_mode   = 1'b0;
  assign rd_if.user_base_addr = base_r;
  assign rd_if.user_end_addr  = end_r;
  assign sched_busy           = sched_busy_r;
  assign frame_done           = frame_done_r;
  assign frame_cnt            = frame_cnt_r;
  assign len_err              = len_err_r;
endmodule

// File: tb/tb_rd_frame_sched.sv
// Directed bench for rd_frame_sched: burst splitting, credit stall, continuous/stop, length errors, reset.
module tb_rd_frame_sched;
  logic        clk = 1'b0;
  logic        reset, ddr_init_done, start, stop, cfg_continuous;
  logic [31:0] cfg_base_addr, cfg_end_addr;
  logic [12:0] cfg_rd_length;
  logic        sched_busy, frame_done, len_err;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fd_cnt   = 0;
  int fd_cyc   = 0;
  logic [31:0] req_addr_q[$];
  logic [12:0] req_len_q[$];
  int          req_cyc_q[$];

  rd_frame_sched_if #(.AXI_ADDR_WIDTH(32)) bus ();

  rd_frame_sched #(
    .AXI_ADDR_WIDTH (32),
    .USER_DATA_WIDTH(16),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ddr_init_done (ddr_init_done),
    .start         (start),
    .stop          (stop),
    .cfg_continuous(cfg_continuous),
    .cfg_base_addr (cfg_base_addr),
    .cfg_end_addr  (cfg_end_addr),
    .cfg_rd_length (cfg_rd_length),
    .rd_if         (bus),
    .sched_busy    (sched_busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .len_err       (len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every request and frame_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.user_rd_req === 1'b1) begin
      req_addr_q.push_back(bus.user_rd_addr);
      req_len_q.push_back(bus.user_rd_length);
      req_cyc_q.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int k = 0;
    while ((req_addr_q.size() < n) && (k < budget)) begin
      tick();
      k++;
    end
    chk("req_wait", 64'(req_addr_q.size() >= n), 64'd1);
  endtask

  task automatic serve(input int idx, input int beats, output int last_cyc);
    wait_reqs(idx + 1, 300);
    last_cyc = cyc;
    for (int i = 0; i < beats; i++) begin
      bus.user_rd_valid = 1'b1;
      bus.user_rd_last  = (i == beats - 1);
      if (i == beats - 1) last_cyc = cyc;
      tick();
    end
    bus.user_rd_valid = 1'b0;
    bus.user_rd_last  = 1'b0;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s     = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic set_cfg(input logic [31:0] b, input logic [31:0] e, input logic [12:0] l, input logic c);
    cfg_base_addr  = b;
    cfg_end_addr   = e;
    cfg_rd_length  = l;
    cfg_continuous = c;
  endtask

  initial begin
    int r0, f0, s, lc, d;
    reset = 1'b1; ddr_init_done = 1'b1; start = 1'b0; stop = 1'b0;
    set_cfg(32'h0, 32'h0, 13'd0, 1'b0);
    bus.user_rd_req_busy = 1'b0;
    bus.user_rd_valid    = 1'b0;
    bus.user_rd_last     = 1'b0;
    tick(2);

    // Reset state
    chk("rst_req", 64'(bus.user_rd_req), 64'd0);
    chk("rst_addr", 64'(bus.user_rd_addr), 64'd0);
    chk("rst_mode", 64'(bus.user_rd_mode), 64'd0);
    chk("rst_base", 64'(bus.user_base_addr), 64'd0);
    chk("rst_busy", 64'(sched_busy), 64'd0);
    chk("rst_fcnt", 64'(frame_cnt), 64'd0);
    chk("rst_err", 64'(len_err), 64'd0);
    reset = 1'b0;
    tick();

    // Frame 0x1000..0x2000 in 1024-byte bursts, credit stall then release
    set_cfg(32'h1000, 32'h2000, 13'd1024, 1'b0);
    r0 = req_addr_q.size(); f0 = fd_cnt;
    pulse_start(s);
    wait_reqs(r0 + 2, 20);
    tick(6);
    chk("stall_two", 64'(req_addr_q.size() - r0), 64'd2);
    chk("start_lat", 64'(req_cyc_q[r0] - s), 64'd2);
    chk("b2b_gap", 64'(req_cyc_q[r0+1] - req_cyc_q[r0]), 64'd2);
    chk("end_lat", 64'(bus.user_end_addr), 64'h2000);
    serve(r0, 512, lc);
    wait_reqs(r0 + 3, 10);
    d = req_cyc_q[r0+2] - lc;
    chk("req3_lat", 64'((d >= 2) && (d <= 3)), 64'd1);
    serve(r0 + 1, 512, lc);
    serve(r0 + 2, 512, lc);
    serve(r0 + 3, 512, lc);
    tick(2);
    chk("fd_once", 64'(fd_cnt - f0), 64'd1);
    chk("fd_lat", 64'(fd_cyc - lc), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", 64'(req_addr_q[r0+i]), 64'(32'h1000 + i * 32'h400));
      chk("t1_len", 64'(req_len_q[r0+i]), 64'd1024);
    end
    chk("t1_nreq", 64'(req_addr_q.size() - r0), 64'd4);
    chk("t1_fcnt", 64'(frame_cnt), 64'd1);
    chk("t1_err", 64'(len_err), 64'd0);
    chk("t1_idle", 64'(sched_busy), 64'd0);
    chk("t1_hold_addr", 64'(bus.user_rd_addr), 64'h1C00);

    // Ragged tail: 0x1000..0x1A00 -> 1024, 1024, 512
    set_cfg(32'h1000, 32'h1A00, 13'd1024, 1'b0);
    r0 = req_addr_q.size();
    pulse_start(s);
    serve(r0, 512, lc);
    serve(r0 + 1, 512, lc);
    serve(r0 + 2, 256, lc);
    tick(3);
    chk("t2_len0", 64'(req_len_q[r0]), 64'd1024);
    chk("t2_len1", 64'(req_len_q[r0+1]), 64'd1024);
    chk("t2_len2", 64'(req_len_q[r0+2]), 64'd512);
    chk("t2_addr2", 64'(req_addr_q[r0+2]), 64'h1800);
    chk("t2_nreq", 64'(req_addr_q.size() - r0), 64'd3);
    chk("t2_err", 64'(len_err), 64'd0);
    chk("t2_fcnt", 64'(frame_cnt), 64'd2);

    // Short burst: 511 beats where 512 expected
    set_cfg(32'h0, 32'h400, 13'd1024, 1'b0);
    r0 = req_addr_q.size();
    pulse_start(s);
    serve(r0, 511, lc);
    tick(3);
    chk("t5_err", 64'(len_err), 64'd1);
    chk("t5_fcnt", 64'(frame_cnt), 64'd3);
    tick(5);
    chk("t5_sticky", 64'(len_err), 64'd1);

    // Continuous mode, stop in frame 3
    set_cfg(32'h0, 32'h400, 13'd256, 1'b1);
    r0 = req_addr_q.size(); f0 = fd_cnt;
    pulse_start(s);
    chk("t4_err_clr", 64'(len_err), 64'd0);
    for (int i = 0; i < 9; i++) begin
      serve(r0 + i, 128, lc);
    end
    wait_reqs(r0 + 11, 10);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    serve(r0 + 9, 128, lc);
    serve(r0 + 10, 128, lc);
    tick(10);
    chk("t4_nreq", 64'(req_addr_q.size() - r0), 64'd11);
    chk("t4_fd", 64'(fd_cnt - f0), 64'd2);
    chk("t4_fcnt", 64'(frame_cnt), 64'd5);
    chk("t4_idle", 64'(sched_busy), 64'd0);
    chk("t4_restart", 64'(req_addr_q[r0+4]), 64'h0);
    chk("t4_addr10", 64'(req_addr_q[r0+10]), 64'h200);
    chk("t4_err", 64'(len_err), 64'd0);

    // Reset during DRAIN, stray last, ignored start, WAIT_INIT
    set_cfg(32'h0, 32'h200, 13'd256, 1'b0);
    r0 = req_addr_q.size();
    pulse_start(s);
    wait_reqs(r0 + 2, 20);
    tick(3);
    chk("t6_busy", 64'(sched_busy), 64'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_busy", 64'(sched_busy), 64'd0);
    chk("t6_rst_fcnt", 64'(frame_cnt), 64'd0);
    chk("t6_rst_addr", 64'(bus.user_rd_addr), 64'd0);
    chk("t6_rst_len", 64'(bus.user_rd_length), 64'd0);
    chk("t6_rst_end", 64'(bus.user_end_addr), 64'd0);
    reset = 1'b0;
    tick();
    bus.user_rd_valid = 1'b1;
    bus.user_rd_last  = 1'b1;
    tick();
    bus.user_rd_valid = 1'b0;
    bus.user_rd_last  = 1'b0;
    tick();
    chk("t6_stray_err", 64'(len_err), 64'd1);
    chk("t6_stray_fcnt", 64'(frame_cnt), 64'd0);
    set_cfg(32'h2000, 32'h2000, 13'd256, 1'b0);
    pulse_start(s);
    tick();
    chk("t6_empty_win", 64'(sched_busy), 64'd0);
    chk("t6_empty_err", 64'(len_err), 64'd1);
    ddr_init_done = 1'b0;
    set_cfg(32'h0, 32'h200, 13'd256, 1'b0);
    r0 = req_addr_q.size();
    pulse_start(s);
    tick(10);
    chk("t6_wait_busy", 64'(sched_busy), 64'd1);
    chk("t6_wait_noreq", 64'(req_addr_q.size() - r0), 64'd0);
    chk("t6_wait_err", 64'(len_err), 64'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_stop_idle", 64'(sched_busy), 64'd0);
    pulse_start(s);
    tick(3);
    ddr_init_done = 1'b1;
    wait_reqs(r0 + 1, 10);
    chk("t6_init_addr", 64'(req_addr_q[r0]), 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
